uart_tx_buffered: RTL and testbench

Buffered UART transmitter that serialises bytes written by the memory-mapped I/O decoder onto the board `tx` pin. It sits directly downstream of the device bus: a store to the UART data address becomes one `wr_en` pulse carrying the byte. Bytes are queued in a FIFO and sent as 8N1 frames at a fixed baud rate derived from the system clock. This frees the CPU from polling per bit and lets it burst several bytes.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 137 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM states, frame width and baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy; full/empty decode from the count.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Gating uses the registered flags, so a push into a full FIFO is lost even when a pop coincides.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter; defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 150000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] head;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 pop;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign baud_tick = (baud_q == BW'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_tick ? '0 : baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          bit_d    = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + CW'(1);
          if (bit_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (baud_tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line and busy flag follow the FSM by one register stage, so both stay frame-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= (state_q != IDLE) || !empty;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at DIV=10; a line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx_buffered;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] d;
    bit         b2b;
    int         fall_at;
  } exp_t;

  logic       clk, reset, wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, tx;
  logic [4:0] count;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  uart_tx_buffered #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .tx      (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit keep, input bit b2b, input bit lat);
    exp_t e;
    wr_en   = 1'b1;
    wr_data = d;
    if (keep) begin
      e.d       = d;
      e.b2b     = b2b;
      e.fall_at = lat ? cyc + 3 : -1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_budget", 32'(k < budget), 32'd1);
  endtask

  // Line monitor: detects a start edge, samples each bit mid-period and scores the frame.
  initial begin
    bit         mon_on;
    int         mt, k, fall_cyc, last_fall;
    logic [10:0] fb;
    exp_t       e;
    mon_on    = 1'b0;
    mt        = 0;
    fall_cyc  = 0;
    last_fall = -100000;
    fb        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_on = 1'b0;
      end else if (!mon_on) begin
        if (tx === 1'b0) begin
          mon_on   = 1'b1;
          mt       = 0;
          fall_cyc = cyc;
          fb       = '0;
        end
      end else begin
        mt++;
      end
      if (mon_on && (mt % DIV) == DIV / 2) begin
        k = mt / DIV;
        fb[k] = tx;
        if (k == NBITS - 1) begin
          mon_on = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, expected no frame (cycle %0d)", fb[8:1], cyc);
          end else begin
            e = exp_q.pop_front();
            chk("start_bit", 32'(fb[0]), 32'd0);
            chk("data_byte", 32'(fb[8:1]), 32'(e.d));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(fb[9]), 32'(^e.d));
`endif
            chk("stop_bit", 32'(fb[NBITS-1]), 32'd1);
            if (e.fall_at >= 0) chk("write_to_fall", 32'(fall_cyc), 32'(e.fall_at));
            if (e.b2b) chk("fall_to_fall", 32'(fall_cyc - last_fall), 32'(NBITS * DIV + 1));
          end
          last_fall = fall_cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", {27'd0, tx, empty, busy, count == 5'd0, full}, {27'd0, 5'b11010});
    reset = 1'b0;

    // Quiet line after reset release.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("idle_outputs", {24'd0, tx, empty, busy, count}, {24'd0, 3'b110, 5'd0});
    end

    // Single byte: latency, frame content, busy drop.
    wr(8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("tx_fall_latency", 32'(tx), 32'd0);
    repeat (NBITS * DIV - 1) @(negedge clk);
    chk("busy_before_drop", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_drop", 32'(busy), 32'd0);
    drain(400);

    // Three consecutive writes; the first is popped while the others arrive.
    repeat (5) @(negedge clk);
    wr(8'h00, 1'b1, 1'b0, 1'b1);
    wr(8'hFF, 1'b1, 1'b1, 1'b0);
    wr(8'h55, 1'b1, 1'b1, 1'b0);
    chk("count_peak", 32'(count), 32'd2);
    repeat (NBITS * DIV + 2) @(negedge clk);
    chk("count_after_pop2", 32'(count), 32'd1);
    repeat (NBITS * DIV + 1) @(negedge clk);
    chk("count_after_pop3", 32'(count), 32'd0);
    drain(600);

    // Overflow: 18 writes, one early pop, so the 18th is dropped.
    repeat (5) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (i == 17) chk("full_at_18th", 32'(full), 32'd1);
      wr(8'(i), i < 17, i > 0 && i < 17, i == 0);
    end
    chk("count_full", 32'(count), 32'd16);
    chk("empty_when_full", 32'(empty), 32'd0);
    drain(17 * (NBITS * DIV + 1) + 300);

    // Reset in the middle of a frame with two bytes still queued.
    repeat (5) @(negedge clk);
    wr(8'h3C, 1'b1, 1'b0, 1'b1);
    wr(8'hAA, 1'b1, 1'b1, 1'b0);
    wr(8'hBB, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    chk("count_before_abort", 32'(count), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("post_abort_quiet", {30'd0, tx, busy}, {30'd0, 2'b10});
    end

`ifdef UART_TX_PARITY_EN
    // Odd population byte gives parity 1; frame spans 11 bit periods.
    wr(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("parity_tx_fall", 32'(tx), 32'd0);
    repeat (NBITS * DIV - 1) @(negedge clk);
    chk("parity_busy_before_drop", 32'(busy), 32'd1);
    @(negedge clk);
    chk("parity_busy_after_drop", 32'(busy), 32'd0);
    drain(400);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
